// File: rtl/imem_dmem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch (read-only) and the data port.
// Data wins ties; a bounded data streak guarantees fetch eventually gets the memory.
module imem_dmem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_waitrequest,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_byteen,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_waitrequest,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_read,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_byteen,
   input  logic                mem_waitrequest,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_rdata_valid
);

   localparam int unsigned BE_W     = DATA_W / 8;
   localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
   localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_D_STREAK);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StCmd    = 2'd1;
   localparam logic [1:0] StRdWait = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   logic [1:0]          state_q, state_d;
   logic                owner_d_q, owner_d_d;  // 1: data port owns the transaction
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     byteen_q, byteen_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   logic d_req;
   logic d_is_write;

   // A simultaneous read+write request is serviced as a plain read.
   assign d_req      = d_read | d_write;
   assign d_is_write = d_write & ~d_read;

   always_comb begin
      state_d   = state_q;
      owner_d_d = owner_d_q;
      streak_d  = streak_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      byteen_d  = byteen_q;
      write_d   = write_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (!i_req) begin
               streak_d = '0;
            end
            if (d_req && (!i_req || (streak_q < MaxStreak))) begin
               owner_d_d = 1'b1;
               addr_d    = d_addr;
               write_d   = d_is_write;
               wdata_d   = d_is_write ? d_wdata : '0;
               byteen_d  = d_is_write ? d_byteen : '1;
               state_d   = StCmd;
               if (i_req) begin
                  streak_d = streak_q + STREAK_W'(1);
               end
            end else if (i_req) begin
               owner_d_d = 1'b0;
               addr_d    = i_addr;
               write_d   = 1'b0;
               wdata_d   = '0;
               byteen_d  = '1;
               streak_d  = '0;
               state_d   = StCmd;
            end
         end
         StCmd: begin
            if (!mem_waitrequest) begin
               state_d = write_q ? StDone : StRdWait;
            end
         end
         StRdWait: begin
            if (mem_rdata_valid) begin
               if (owner_d_q) begin
                  d_rdata_d = mem_rdata;
               end else begin
                  i_rdata_d = mem_rdata;
               end
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         owner_d_q <= 1'b0;
         streak_q  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         byteen_q  <= '0;
         write_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_d_q <= owner_d_d;
         streak_q  <= streak_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         byteen_q  <= byteen_d;
         write_q   <= write_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   always_comb begin
      mem_addr      = addr_q;
      mem_wdata     = wdata_q;
      mem_byteen    = byteen_q;
      mem_read      = (state_q == StCmd) & ~write_q;
      mem_write     = (state_q == StCmd) & write_q;
      i_rdata       = i_rdata_q;
      d_rdata       = d_rdata_q;
      // Completion is signalled only to the owner, and only in the single DONE cycle.
      i_waitrequest = i_req & ~((state_q == StDone) & ~owner_d_q);
      d_waitrequest = d_req & ~((state_q == StDone) & owner_d_q);
   end

endmodule
